// File: rtl/trng_pkg.sv
// Shared types and health-test limits for the TRNG word collector.
// The cutoffs mirror the software health-check model.
package trng_pkg;

   typedef enum logic [1:0] {
      ST_WARMUP  = 2'd0,
      ST_COLLECT = 2'd1,
      ST_FAIL    = 2'd2
   } trng_state_t;

   localparam int unsigned WARMUP_BITS_DEF = 256;
   localparam int unsigned RCT_CUTOFF_DEF  = 32;
   localparam int unsigned APT_WINDOW_DEF  = 1024;
   localparam int unsigned APT_CUTOFF_DEF  = 600;

endpackage

// File: rtl/trng_sync_fifo.sv
// Synchronous FIFO with level output and simultaneous push/pop.
// DEPTH must be a power of two, at least 2.
module trng_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = count == LW'(DEPTH);
   assign empty   = count == '0;
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a push when a pop frees the slot this cycle
   assign do_push = push && (!full || do_pop);
   assign level   = count;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + LW'(do_push) - LW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/trng_word_collector.sv
// Collects ring-generator bits into words behind warm-up and
// continuous repetition-count / adaptive-proportion health tests.
module trng_word_collector
   import trng_pkg::*;
#(
   parameter int unsigned WORD_W      = 32,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned WARMUP_BITS = WARMUP_BITS_DEF,
   parameter int unsigned RCT_CUTOFF  = RCT_CUTOFF_DEF,
   parameter int unsigned APT_WINDOW  = APT_WINDOW_DEF,
   parameter int unsigned APT_CUTOFF  = APT_CUTOFF_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          bit_in,
   input  logic                          clr_fail,
   output logic [WORD_W-1:0]             word_data,
   output logic                          word_valid,
   input  logic                          word_ready,
   output logic                          health_fail,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned WC_W  = $clog2(WARMUP_BITS + 1);
   localparam int unsigned BC_W  = $clog2(WORD_W + 1);
   localparam int unsigned RUN_W = $clog2(RCT_CUTOFF + 1);
   localparam int unsigned POS_W = $clog2(APT_WINDOW);
   localparam int unsigned MAT_W = $clog2(APT_WINDOW + 1);

   trng_state_t      state;
   logic [WC_W-1:0]  warm_cnt;
   logic [BC_W-1:0]  bit_cnt;
   logic [WORD_W-1:0] word_q;
   logic [RUN_W-1:0] run_cnt;
   logic             last_bit;
   logic [POS_W-1:0] apt_pos;
   logic             apt_ref;
   logic [MAT_W-1:0] apt_match;

   logic              sample;
   logic [RUN_W-1:0]  run_nxt;
   logic              win_start;
   logic [MAT_W-1:0]  match_nxt;
   logic [POS_W-1:0]  pos_nxt;
   logic              fail_now;
   logic [WORD_W-1:0] shift_word;
   logic              holding;
   logic              word_done;
   logic              pop;
   logic              room;
   logic              push;
   logic [WORD_W-1:0] push_data;
   logic              fifo_clear;
   logic              fifo_full;
   logic              fifo_empty;

   always_comb begin
      sample    = en && (state != ST_FAIL);
      // run_cnt==0 means no bit has been seen since reset/clear
      if (run_cnt == '0 || bit_in != last_bit)
         run_nxt = RUN_W'(1);
      else
         run_nxt = run_cnt + 1'b1;
      win_start = apt_pos == '0;
      if (win_start)
         match_nxt = MAT_W'(1);
      else
         match_nxt = apt_match + MAT_W'(bit_in == apt_ref);
      if (apt_pos == POS_W'(APT_WINDOW - 1))
         pos_nxt = '0;
      else
         pos_nxt = apt_pos + 1'b1;
      fail_now  = sample &&
                  (run_nxt == RUN_W'(RCT_CUTOFF) ||
                   match_nxt == MAT_W'(APT_CUTOFF));
      shift_word = {word_q[WORD_W-2:0], bit_in};
      holding    = bit_cnt == BC_W'(WORD_W);
      word_done  = en && bit_cnt == BC_W'(WORD_W - 1);
      pop        = word_valid && word_ready;
      room       = !fifo_full || pop;
      push       = (state == ST_COLLECT) && !fail_now && room &&
                   (holding || word_done);
      push_data  = holding ? word_q : shift_word;
      fifo_clear = fail_now || (state == ST_FAIL && clr_fail);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_WARMUP;
         health_fail <= 1'b0;
         warm_cnt    <= '0;
         bit_cnt     <= '0;
         word_q      <= '0;
         run_cnt     <= '0;
         last_bit    <= 1'b0;
         apt_pos     <= '0;
         apt_ref     <= 1'b0;
         apt_match   <= '0;
      end else begin
         if (sample) begin
            last_bit  <= bit_in;
            run_cnt   <= run_nxt;
            apt_match <= match_nxt;
            apt_pos   <= pos_nxt;
            if (win_start)
               apt_ref <= bit_in;
         end
         if (fail_now) begin
            state       <= ST_FAIL;
            health_fail <= 1'b1;
            bit_cnt     <= '0;
            word_q      <= '0;
         end else begin
            unique case (state)
               ST_WARMUP: begin
                  if (en) begin
                     warm_cnt <= warm_cnt + 1'b1;
                     if (warm_cnt == WC_W'(WARMUP_BITS - 1))
                        state <= ST_COLLECT;
                  end
               end
               ST_COLLECT: begin
                  // A completed word waits in word_q until the FIFO has room
                  if (holding) begin
                     if (room)
                        bit_cnt <= '0;
                  end else if (en) begin
                     word_q <= shift_word;
                     if (word_done)
                        bit_cnt <= room ? '0 : BC_W'(WORD_W);
                     else
                        bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               ST_FAIL: begin
                  if (clr_fail) begin
                     state       <= ST_WARMUP;
                     health_fail <= 1'b0;
                     warm_cnt    <= '0;
                     bit_cnt     <= '0;
                     word_q      <= '0;
                     run_cnt     <= '0;
                     last_bit    <= 1'b0;
                     apt_pos     <= '0;
                     apt_ref     <= 1'b0;
                     apt_match   <= '0;
                  end
               end
               default: state <= ST_WARMUP;
            endcase
         end
      end
   end

   trng_sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (fifo_clear),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (word_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign word_valid = !fifo_empty;

endmodule

// File: tb/tb_trng_word_collector.sv
// Directed bench for trng_word_collector: table of phases plus
// hand-written reset and adaptive-proportion sequences.
module tb_trng_word_collector;

   localparam logic [1:0] M_ALT  = 2'd0;
   localparam logic [1:0] M_ONE  = 2'd1;
   localparam logic [1:0] M_ZERO = 2'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        bit_in;
   logic        clr_fail;
   logic [31:0] word_data;
   logic        word_valid;
   logic        word_ready;
   logic        health_fail;
   logic [2:0]  fifo_level;

   int n_tests = 0;
   int n_fail  = 0;
   logic alt;

   typedef struct {
      string       name;
      logic        en;
      logic [1:0]  mode;
      int          n;
      logic        ready;
      logic        clr;
      logic        exp_valid;
      int          exp_level;
      logic        exp_fail;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [21];

   always #5 clk = ~clk;

   trng_word_collector dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .bit_in      (bit_in),
      .clr_fail    (clr_fail),
      .word_data   (word_data),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .health_fail (health_fail),
      .fifo_level  (fifo_level)
   );

   function automatic vec_t mk(string nm, logic e, logic [1:0] m,
                               int n, logic r, logic c, logic v,
                               int lvl, logic f, logic [31:0] d);
      vec_t t;
      t.name = nm; t.en = e; t.mode = m; t.n = n; t.ready = r;
      t.clr = c; t.exp_valid = v; t.exp_level = lvl;
      t.exp_fail = f; t.exp_data = d;
      return t;
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic e, input logic b,
                       input logic r, input logic c);
      en = e; bit_in = b; word_ready = r; clr_fail = c;
      @(posedge clk);
      #1;
   endtask

   task automatic next_bit(input logic [1:0] m, output logic b);
      if (m == M_ALT) begin
         b = alt;
         alt = ~alt;
      end else begin
         b = (m == M_ONE);
      end
   endtask

   task automatic do_reset();
      en = 1'b0; bit_in = 1'b0; word_ready = 1'b0; clr_fail = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic b;
      vecs[0]  = mk("warmup",     1, M_ALT, 287, 0, 0, 0, 0, 0, 32'h0);
      vecs[1]  = mk("first_word", 1, M_ALT,   1, 0, 0, 1, 1, 0, 32'h55555555);
      vecs[2]  = mk("fill",       1, M_ALT,  96, 0, 0, 1, 4, 0, 32'h55555555);
      vecs[3]  = mk("held_word",  1, M_ALT,  32, 0, 0, 1, 4, 0, 32'h55555555);
      vecs[4]  = mk("stall_bits", 1, M_ALT,  21, 0, 0, 1, 4, 0, 32'h55555555);
      vecs[5]  = mk("pop_push",   0, M_ZERO,  1, 1, 0, 1, 4, 0, 32'h55555555);
      vecs[6]  = mk("pop2",       0, M_ZERO,  1, 1, 0, 1, 3, 0, 32'h55555555);
      vecs[7]  = mk("pop3",       0, M_ZERO,  1, 1, 0, 1, 2, 0, 32'h55555555);
      vecs[8]  = mk("pop4_held",  0, M_ZERO,  1, 1, 0, 1, 1, 0, 32'h55555555);
      vecs[9]  = mk("pop5_empty", 0, M_ZERO,  1, 1, 0, 0, 0, 0, 32'h0);
      vecs[10] = mk("next_word",  1, M_ALT,  32, 0, 0, 1, 1, 0, 32'hAAAAAAAA);
      vecs[11] = mk("en_idle",    0, M_ZERO,  5, 0, 0, 1, 1, 0, 32'hAAAAAAAA);
      vecs[12] = mk("partial",    1, M_ALT,  16, 0, 0, 1, 1, 0, 32'hAAAAAAAA);
      vecs[13] = mk("ones31",     1, M_ONE,  31, 0, 0, 1, 2, 0, 32'hAAAAAAAA);
      vecs[14] = mk("ones32_rct", 1, M_ONE,   1, 0, 0, 0, 0, 1, 32'h0);
      vecs[15] = mk("fail_ones",  1, M_ONE,  10, 0, 0, 0, 0, 1, 32'h0);
      vecs[16] = mk("fail_alt",   1, M_ALT, 300, 1, 0, 0, 0, 1, 32'h0);
      vecs[17] = mk("clr_fail",   0, M_ZERO,  1, 0, 1, 0, 0, 0, 32'h0);
      vecs[18] = mk("rewarm",     1, M_ALT, 287, 0, 0, 0, 0, 0, 32'h0);
      vecs[19] = mk("reword",     1, M_ALT,   1, 0, 0, 1, 1, 0, 32'hAAAAAAAA);
      vecs[20] = mk("clr_ignore", 0, M_ZERO,  1, 0, 1, 1, 1, 0, 32'hAAAAAAAA);

      do_reset();
      check("rst_valid", 32'(word_valid), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_fail", 32'(health_fail), 32'd0);
      check("rst_data", word_data, 32'd0);

      alt = 1'b0;
      for (int i = 0; i < 21; i++) begin
         for (int k = 0; k < vecs[i].n; k++) begin
            next_bit(vecs[i].mode, b);
            step(vecs[i].en, b, vecs[i].ready, vecs[i].clr);
         end
         check({vecs[i].name, "_valid"}, 32'(word_valid),
               32'(vecs[i].exp_valid));
         check({vecs[i].name, "_level"}, 32'(fifo_level),
               32'(vecs[i].exp_level));
         check({vecs[i].name, "_fail"}, 32'(health_fail),
               32'(vecs[i].exp_fail));
         if (vecs[i].exp_valid)
            check({vecs[i].name, "_data"}, word_data, vecs[i].exp_data);
      end

      // asynchronous reset with 17 bits of a word packed
      alt = 1'b0;
      for (int k = 0; k < 17; k++) begin
         next_bit(M_ALT, b);
         step(1'b1, b, 1'b0, 1'b0);
      end
      en = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(word_valid), 32'd0);
      check("arst_level", 32'(fifo_level), 32'd0);
      check("arst_data", word_data, 32'd0);
      check("arst_fail", 32'(health_fail), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      alt = 1'b0;
      for (int k = 0; k < 287; k++) begin
         next_bit(M_ALT, b);
         step(1'b1, b, 1'b0, 1'b0);
      end
      check("arst_rewarm_valid", 32'(word_valid), 32'd0);
      next_bit(M_ALT, b);
      step(1'b1, b, 1'b0, 1'b0);
      check("arst_word_valid", 32'(word_valid), 32'd1);
      check("arst_word_data", word_data, 32'h55555555);

      // APT: reference 1, pattern 110, 600th match at bit 898
      do_reset();
      for (int i = 0; i < 898; i++)
         step(1'b1, (i % 3) != 2, 1'b1, 1'b0);
      check("apt599_nofail", 32'(health_fail), 32'd0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("apt600_fail", 32'(health_fail), 32'd1);
      check("apt600_level", 32'(fifo_level), 32'd0);

      // APT: 599 matches in a full window, then a fresh window
      do_reset();
      for (int i = 0; i < 1024; i++) begin
         if (i < 522)
            b = (i % 3) != 2;
         else
            b = ((i - 522) % 2) == 0;
         step(1'b1, b, 1'b1, 1'b0);
      end
      check("apt_win599", 32'(health_fail), 32'd0);
      for (int i = 0; i < 200; i++)
         step(1'b1, (i % 2) == 0, 1'b1, 1'b0);
      check("apt_restart", 32'(health_fail), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
